// File: rtl/tone_sequencer.sv
// Multi-note square-wave tone sequencer: plays a runtime-loaded table of half-period
// counts as a signed PCM square wave, one-shot or looping, ascending or descending.
module tone_sequencer #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int NUM_NOTES       = 4,
    parameter int DIV_WIDTH       = 19,
    parameter int NOTE_MS         = 200,
    parameter int GAP_MS          = 0,
    parameter int AMPLITUDE       = 10000000,
    localparam int IDX_W          = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1
) (
    input  logic                           CLOCK_50,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           stop,
    input  logic                           descend,
    input  logic                           loop,
    input  logic [NUM_NOTES*DIV_WIDTH-1:0] note_table,
    output logic [31:0]                    sample,
    output logic                           busy,
    output logic                           done,
    output logic [IDX_W-1:0]               note_idx,
    output logic [1:0]                     state_dbg
);

    localparam logic [31:0]      NOTE_CYC = 32'(CLOCK_FREQUENCY / 1000 * NOTE_MS);
    localparam logic [31:0]      GAP_CYC  = 32'(CLOCK_FREQUENCY / 1000 * GAP_MS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NOTES - 1);
    localparam logic [31:0]      AMP_POS  = 32'(AMPLITUDE);
    localparam logic [31:0]      AMP_NEG  = 32'(-AMPLITUDE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       note_idx_q, note_idx_d;
    logic [31:0]            dur_q, dur_d;
    logic [DIV_WIDTH-1:0]   phase_q, phase_d;
    logic                   level_q, level_d;
    logic                   descend_q, descend_d;
    logic                   loop_q, loop_d;
    logic                   start_prev_q, start_prev_d;
    logic [31:0]            sample_q, sample_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [DIV_WIDTH-1:0]   cur_entry;
    logic                   start_edge;
    logic                   is_last;
    logic [IDX_W-1:0]       first_idx;
    logic [IDX_W-1:0]       step_idx;
    logic                   advance;

    always_comb begin
        cur_entry  = note_table[int'(note_idx_q) * DIV_WIDTH +: DIV_WIDTH];
        start_edge = start & ~start_prev_q;
        first_idx  = descend_q ? LAST_IDX : '0;
        is_last    = (note_idx_q == (descend_q ? '0 : LAST_IDX));
        step_idx   = descend_q ? (note_idx_q - IDX_W'(1)) : (note_idx_q + IDX_W'(1));
    end

    // start is a level input: only a 0->1 transition seen in IDLE launches a sequence.
    // stop overrides everything, including a launch or a completion in the same cycle.
    always_comb begin
        state_d      = state_q;
        note_idx_d   = note_idx_q;
        dur_d        = dur_q;
        phase_d      = phase_q;
        level_d      = level_q;
        descend_d    = descend_q;
        loop_d       = loop_q;
        start_prev_d = start;
        done_d       = 1'b0;
        advance      = 1'b0;

        // Registered one cycle behind the state and level that produce it.
        if (state_q == S_PLAY && cur_entry != '0) begin
            sample_d = level_q ? AMP_POS : AMP_NEG;
        end else begin
            sample_d = '0;
        end

        if (stop) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_edge) begin
                        state_d    = S_PLAY;
                        descend_d  = descend;
                        loop_d     = loop;
                        note_idx_d = descend ? LAST_IDX : '0;
                        dur_d      = '0;
                        phase_d    = '0;
                        level_d    = 1'b1;
                    end
                end
                S_PLAY: begin
                    if (phase_q == cur_entry) begin
                        phase_d = '0;
                        level_d = ~level_q;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                    if (dur_q == NOTE_CYC - 32'd1) begin
                        if (GAP_CYC != 32'd0) begin
                            state_d = S_GAP;
                            dur_d   = '0;
                        end else begin
                            advance = 1'b1;
                        end
                    end else begin
                        dur_d = dur_q + 32'd1;
                    end
                end
                S_GAP: begin
                    if (dur_q == GAP_CYC - 32'd1) begin
                        advance = 1'b1;
                    end else begin
                        dur_d = dur_q + 32'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            if (advance) begin
                dur_d   = '0;
                phase_d = '0;
                level_d = 1'b1;
                if (!is_last) begin
                    note_idx_d = step_idx;
                    state_d    = S_PLAY;
                end else if (loop_q) begin
                    note_idx_d = first_idx;
                    state_d    = S_PLAY;
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            note_idx_q   <= '0;
            dur_q        <= '0;
            phase_q      <= '0;
            level_q      <= 1'b0;
            descend_q    <= 1'b0;
            loop_q       <= 1'b0;
            start_prev_q <= 1'b1;
            sample_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            note_idx_q   <= note_idx_d;
            dur_q        <= dur_d;
            phase_q      <= phase_d;
            level_q      <= level_d;
            descend_q    <= descend_d;
            loop_q       <= loop_d;
            start_prev_q <= start_prev_d;
            sample_q     <= sample_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign sample    = sample_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign note_idx  = note_idx_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: two instances (no gap / 10-cycle gap) driven in parallel and
// compared every cycle against a sequence-level reference model.
module tb_tone_sequencer;

    localparam int CF     = 10000;
    localparam int N      = 3;
    localparam int DW     = 8;
    localparam int NOTE_C = CF / 1000 * 2;
    localparam int GAP_A  = 0;
    localparam int GAP_B  = CF / 1000 * 1;
    localparam int AMP    = 10000000;
    localparam int IW     = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            stop;
    logic            descend;
    logic            loop;
    logic [N*DW-1:0] table_v;

    logic [31:0]     sample_a, sample_b;
    logic            busy_a, busy_b, done_a, done_b;
    logic [IW-1:0]   idx_a, idx_b;
    logic [1:0]      st_a, st_b;

    tone_sequencer #(
        .CLOCK_FREQUENCY(CF), .NUM_NOTES(N), .DIV_WIDTH(DW),
        .NOTE_MS(2), .GAP_MS(0), .AMPLITUDE(AMP)
    ) dut_a (
        .CLOCK_50(clk), .reset(rst_n), .start(start), .stop(stop),
        .descend(descend), .loop(loop), .note_table(table_v),
        .sample(sample_a), .busy(busy_a), .done(done_a),
        .note_idx(idx_a), .state_dbg(st_a)
    );

    tone_sequencer #(
        .CLOCK_FREQUENCY(CF), .NUM_NOTES(N), .DIV_WIDTH(DW),
        .NOTE_MS(2), .GAP_MS(1), .AMPLITUDE(AMP)
    ) dut_b (
        .CLOCK_50(clk), .reset(rst_n), .start(start), .stop(stop),
        .descend(descend), .loop(loop), .note_table(table_v),
        .sample(sample_b), .busy(busy_b), .done(done_b),
        .note_idx(idx_b), .state_dbg(st_b)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // st: 0 idle, 1 playing, 2 gap. k is the position in the sequence, t the cycles spent
    // in the current note or gap; the square-wave level is derived directly from t.
    typedef struct {
        int          st;
        int          k;
        int          t;
        bit          desc;
        bit          lp;
        bit          prev;
        int          idx;
        logic [31:0] smp;
        bit          busy;
        bit          done;
    } model_t;

    model_t m_a, m_b;
    logic [31:0] exp_q[$];

    function automatic int entry_of(int i);
        return int'(table_v[i*DW +: DW]);
    endfunction

    function automatic model_t advance_note(model_t m);
        model_t n = m;
        n.t = 0;
        if (n.k < N - 1) begin
            n.k  = n.k + 1;
            n.st = 1;
        end else if (n.lp) begin
            n.k  = 0;
            n.st = 1;
        end else begin
            n.st   = 0;
            n.done = 1'b1;
        end
        n.idx = n.desc ? (N - 1 - n.k) : n.k;
        return n;
    endfunction

    function automatic model_t model_next(model_t m, int gap_cyc);
        model_t n = m;
        int     e;
        bit     lvl;
        if (!rst_n) begin
            n = '{default: 0};
            n.prev = 1'b1;
            return n;
        end
        e   = entry_of(m.idx);
        lvl = (m.t % (2 * (e + 1))) < (e + 1);
        n.smp  = (m.st == 1 && e != 0) ? (lvl ? 32'(AMP) : 32'(-AMP)) : 32'd0;
        n.done = 1'b0;
        n.prev = start;
        if (stop) begin
            n.st = 0;
        end else begin
            case (m.st)
                0: if (start && !m.prev) begin
                    n.st   = 1;
                    n.desc = descend;
                    n.lp   = loop;
                    n.k    = 0;
                    n.t    = 0;
                    n.idx  = descend ? N - 1 : 0;
                end
                1: if (m.t == NOTE_C - 1) begin
                    if (gap_cyc > 0) begin
                        n.st = 2;
                        n.t  = 0;
                    end else begin
                        n = advance_note(n);
                    end
                end else begin
                    n.t = m.t + 1;
                end
                default: if (m.t == gap_cyc - 1) n = advance_note(n);
                         else n.t = m.t + 1;
            endcase
        end
        n.busy = (n.st != 0);
        return n;
    endfunction

    always @(posedge clk) begin
        m_a = model_next(m_a, GAP_A);
        m_b = model_next(m_b, GAP_B);
        exp_q.push_back(m_a.smp);
        exp_q.push_back(m_b.smp);
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    bit checking = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] ea, eb;
        if (exp_q.size() >= 2) begin
            ea = exp_q.pop_front();
            eb = exp_q.pop_front();
            if (checking) begin
                check_val("sample_a", sample_a, ea);
                check_val("busy_a", 32'(busy_a), 32'(m_a.busy));
                check_val("done_a", 32'(done_a), 32'(m_a.done));
                check_val("idx_a", 32'(idx_a), 32'(m_a.idx));
                check_val("state_a", 32'(st_a), 32'(m_a.st));
                check_val("sample_b", sample_b, eb);
                check_val("busy_b", 32'(busy_b), 32'(m_b.busy));
                check_val("done_b", 32'(done_b), 32'(m_b.done));
                check_val("idx_b", 32'(idx_b), 32'(m_b.idx));
                check_val("state_b", 32'(st_b), 32'(m_b.st));
            end
        end
    end

    // ---------------- drivers ----------------
    int busy_cnt_a, busy_cnt_b, done_cnt_a, done_cnt_b;

    task automatic step();
        @(negedge clk);
        #1;
        busy_cnt_a += int'(busy_a);
        busy_cnt_b += int'(busy_b);
        done_cnt_a += int'(done_a);
        done_cnt_b += int'(done_b);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clr_counts();
        busy_cnt_a = 0;
        busy_cnt_b = 0;
        done_cnt_a = 0;
        done_cnt_b = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Entry 0 -> half-period 2, entry 1 -> half-period 4, entry 2 -> rest.
    task automatic load_ref_table();
        table_v = {8'd0, 8'd3, 8'd1};
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b1;
        stop    = 1'b0;
        descend = 1'b0;
        loop    = 1'b0;
        load_ref_table();
        clr_counts();
        run(2);
        checking = 1'b1;
        run(2);

        // start held high across reset release must not launch
        rst_n = 1'b1;
        clr_counts();
        run(6);
        check_val("held_start_busy", 32'(busy_cnt_a + busy_cnt_b), 32'd0);
        start = 1'b0;
        step();

        // ascending one-shot
        clr_counts();
        pulse_start();
        run(100);
        check_val("asc_busy_cyc_a", 32'(busy_cnt_a), 32'd60);
        check_val("asc_busy_cyc_b", 32'(busy_cnt_b), 32'd90);
        check_val("asc_done_cnt_a", 32'(done_cnt_a), 32'd1);
        check_val("asc_done_cnt_b", 32'(done_cnt_b), 32'd1);

        // descending one-shot
        descend = 1'b1;
        clr_counts();
        pulse_start();
        descend = 1'b0;
        run(100);
        check_val("desc_busy_cyc_a", 32'(busy_cnt_a), 32'd60);
        check_val("desc_done_cnt_a", 32'(done_cnt_a), 32'd1);
        check_val("desc_done_cnt_b", 32'(done_cnt_b), 32'd1);

        // looping, re-pulsed start mid-note, then stop during second-pass note 1
        loop = 1'b1;
        clr_counts();
        pulse_start();
        loop = 1'b0;
        run(10);
        pulse_start();
        run(76);
        stop = 1'b1;
        step();
        stop = 1'b0;
        run(5);
        check_val("loop_done_cnt_a", 32'(done_cnt_a), 32'd0);
        check_val("loop_done_cnt_b", 32'(done_cnt_b), 32'd0);

        // reset mid-play, then a fresh launch
        pulse_start();
        run(15);
        rst_n = 1'b0;
        run(2);
        rst_n = 1'b1;
        run(2);
        clr_counts();
        pulse_start();
        run(100);
        check_val("rst_replay_done_a", 32'(done_cnt_a), 32'd1);
        check_val("rst_replay_busy_b", 32'(busy_cnt_b), 32'd90);

        // randomized sequences with stray start toggles and stops
        for (int it = 0; it < 14; it++) begin
            int n_cyc;
            for (int j = 0; j < N; j++) table_v[j*DW +: DW] = 8'($urandom_range(0, 6));
            descend = 1'($urandom_range(0, 1));
            loop    = 1'($urandom_range(0, 1));
            pulse_start();
            n_cyc = $urandom_range(20, 200);
            for (int c = 0; c < n_cyc; c++) begin
                if ($urandom_range(0, 19) == 0) start = ~start;
                stop = ($urandom_range(0, 79) == 0);
                step();
            end
            stop  = 1'b1;
            start = 1'b0;
            step();
            stop = 1'b0;
            run(3);
        end

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
